// File: rtl/mux16_serializer_if.sv
// Bus bundle between the serializer, its upstream word source and the 16:1 mux tree.
// master = environment side (word source + mux), slave = serializer side.
interface mux16_serializer_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  mux_sel;
  logic [15:0] mux_i;
  logic        mux_y;
  logic        ser_out;
  logic        ser_valid;
  logic        last;
  logic        busy;

  modport master (
    output load_valid, load_data, mux_y,
    input  load_ready, mux_sel, mux_i, ser_out, ser_valid, last, busy
  );

  modport slave (
    input  load_valid, load_data, mux_y,
    output load_ready, mux_sel, mux_i, ser_out, ser_valid, last, busy
  );
endinterface

// File: rtl/mux16_serializer.sv
// Sequencer feeding a combinational 16:1 mux: holds a word on the mux data inputs,
// walks the select through all positions and registers mux_y into a serial stream.
module mux16_serializer #(
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  mux16_serializer_if.slave   bus
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] FIRST    = LSB_FIRST ? CW'(0) : CW'(W - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   sel_q, sel_d;
  logic [W-1:0]    mux_i_q, mux_i_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_valid_q, ser_valid_d;
  logic            last_q, last_d;

  logic            load_ready_c;
  logic            accept_c;
  logic            final_bit_c;

  // A new word may enter while idle or during the final select position of the current word.
  assign final_bit_c  = (state_q == SHIFT) && (count_q == LAST_IDX);
  assign load_ready_c = (state_q == IDLE) || final_bit_c;
  assign accept_c     = bus.load_valid && load_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sel_q       <= '0;
      mux_i_q     <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sel_q       <= sel_d;
      mux_i_q     <= mux_i_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      last_q      <= last_d;
    end
  end

  // mux_y reflects the select registered on the previous edge, so it is captured directly.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sel_d       = sel_q;
    mux_i_d     = mux_i_q;
    ser_out_d   = IDLE_LEVEL;
    ser_valid_d = 1'b0;
    last_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mux_i_d = bus.load_data;
          sel_d   = FIRST;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_out_d   = bus.mux_y;
        ser_valid_d = 1'b1;
        last_d      = (count_q == LAST_IDX);
        if (count_q != LAST_IDX) begin
          count_d = count_q + CW'(1);
          sel_d   = LSB_FIRST ? (sel_q + CW'(1)) : (sel_q - CW'(1));
        end else if (accept_c) begin
          mux_i_d = bus.load_data;
          sel_d   = FIRST;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.load_ready = load_ready_c;
  assign bus.mux_sel    = sel_q;
  assign bus.mux_i      = mux_i_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = (state_q == SHIFT);

endmodule

// File: doc/mux16_serializer.md
Name: mux16_serializer

Overview:
- Sequencer stage directly upstream of the team's 16:1 mux tree (mux16to1_2).
- Accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Walks the mux select through all 16 positions and registers the mux output into a serial bit stream with valid/last flags.
- Back-to-back words stream with no gap cycles.

Parameters:
- LSB_FIRST, 1, 1 = select order 0→15; 0 = select order 15→0.
- IDLE_LEVEL, 1'b1, value driven on ser_out whenever ser_valid = 0.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  upstream word valid.
- load_data  in  16  upstream word.
- load_ready  out  1  combinational; word accepted on the edge where load_valid && load_ready.
- mux_sel  out  4  registered; drives the mux select.
- mux_i  out  16  registered; drives the mux data inputs.
- mux_y  in  1  combinational mux output.
- ser_out  out  1  registered serial bit.
- ser_valid  out  1  registered; ser_out carries a data bit.
- last  out  1  registered; high with the 16th bit of a word.
- busy  out  1  high while in state SHIFT.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, count = 0, mux_sel = 0, mux_i = 0, ser_out = IDLE_LEVEL, ser_valid = 0, last = 0, busy = 0.
- Reset mid-word aborts immediately. No further bits are emitted and last does not assert.
- Definitions: FIRST = LSB_FIRST ? 0 : 15. Count is a 4-bit bit index.
- load_ready = (state == IDLE) || (state == SHIFT && count == 15).
- IDLE:
  - On accept: mux_i ← load_data, mux_sel ← FIRST, count ← 0, go to SHIFT.
  - ser_valid ← 0, ser_out ← IDLE_LEVEL, last ← 0.
- SHIFT, every cycle:
  - ser_out ← mux_y, ser_valid ← 1, last ← (count == 15).
- SHIFT, count < 15:
  - count ← count + 1.
  - mux_sel ← mux_sel + 1 if LSB_FIRST, else mux_sel − 1.
  - mux_i is held.
- SHIFT, count == 15 with accept:
  - mux_i ← load_data, mux_sel ← FIRST, count ← 0, stay in SHIFT.
  - Produces a continuous stream with no idle cycle.
- SHIFT, count == 15 without accept: go to IDLE. mux_sel and mux_i keep their last values.
- Latency: for a word accepted on edge T, bit n appears on ser_out during cycle T+2+n (n = 0..15). last is high in cycle T+17.
- The mux is purely combinational, so mux_y is sampled one edge after mux_sel updates. No extra pipeline stage is allowed.
- mux_i is stable for all 16 bits of a word. Upstream changes to load_data have no effect except on an accept edge.
- load_valid while load_ready = 0 is ignored. Upstream must hold the word until accepted.
- mux_sel wrap: the sequencer never steps past 15 (LSB_FIRST) or below 0 (MSB-first) within a word. Reload to FIRST happens only at count == 15.
- busy = (state == SHIFT). It stays high across back-to-back words.

Test Plan:
- Reset check: assert rst asynchronously between edges → all outputs reach their reset values immediately, with ser_out = 1 (default IDLE_LEVEL) and load_ready = 1.
- Single word, LSB_FIRST = 1, load 16'hA5C3 → ser_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over cycles T+2..T+17. ser_valid is high for exactly those 16 cycles, last only at T+17, then IDLE.
- Back-to-back: 16'hFFFF, then 16'h0000 presented with load_valid held → 16 ones then 16 zeros with no gap. last pulses at T+17 and T+33. load_ready is high only in the count == 15 cycles while busy.
- LSB_FIRST = 0, load 16'h8001 → mux_sel walks 15→0. ser_out is 1,0×14,1; word 16'h0003 yields 0×14,1,1.
- Reset at bit 7 of 16'hFFFF → ser_valid drops at once, no last pulse. A subsequent load of 16'h0001 streams correctly from bit 0.
- load_valid with 16'h1234 asserted during bits 2..14 of a word → not accepted, no effect on mux_i. It is accepted only at count == 15 and emitted next.
